pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Generates the stall, flush and freeze controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//  Detects load-use hazards and taken-branch redirects.
//  Runs a wait-state FSM against a data memory that may respond late, with a watchdog timeout.
//  Keeps saturating counters of stall and flush events for performance debug.
// PARAMETERS
//  MEM_TIMEOUT  16  maximum MEM_WAIT cycles before giving up; must be >= 2
//  CNT_W        32  width of the stall and flush event counters
// PORTS
//  clk              in   1      system clock; all state updates on its rising edge
//  rst              in   1      synchronous, active-high reset
//  ID_EX_MemRead    in   1      the instruction in EX is a load
//  ID_EX_Rd         in   5      destination register of the instruction in EX
//  IF_ID_Rs1        in   5      source register 1 of the instruction in ID
//  IF_ID_Rs2        in   5      source register 2 of the instruction in ID
//  branch_taken     in   1      EX resolved a taken branch or jump this cycle
//  EX_MEM_MemRead   in   1      MEM stage is performing a load
//  EX_MEM_MemWrite  in   1      MEM stage is performing a store
//  dmem_ready       in   1      data memory completes the MEM-stage access this cycle
//  PC_Stall         out  1      hold PC
//  IF_ID_Stall      out  1      hold the IF/ID register
//  IF_ID_Flush      out  1      invalidate the IF/ID contents
//  Control_Sig_Stall out 1      hold the ID/EX register
//  ID_EX_Bubble     out  1      load zeros into the ID/EX control fields (NOP)
//  Pipe_Freeze      out  1      hold the EX/MEM and MEM/WB registers
//  mem_timeout      out  1      sticky error flag; cleared only by rst
//  stall_cnt        out  CNT_W  count of cycles with PC_Stall=1; saturates at all-ones
//  flush_cnt        out  CNT_W  count of cycles with IF_ID_Flush=1; saturates at all-ones
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0; all control outputs 0 while rst=1.
//  Hazard conditions (combinational):
//   mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready
//   load_use = ID_EX_MemRead & (ID_EX_Rd != 0) & (ID_EX_Rd == IF_ID_Rs1 | ID_EX_Rd == IF_ID_Rs2)
//  Control outputs are combinational from state and inputs. They take effect in the same cycle, with zero latency.
//  Priority: freeze > flush > load-use.
//  State RUN:
//   mem_busy -> PC_Stall, IF_ID_Stall, Control_Sig_Stall and Pipe_Freeze =1; next state MEM_WAIT; wait_cnt<=1.
//   else branch_taken -> IF_ID_Flush=1, ID_EX_Bubble=1; PC not stalled (redirect loads).
//    load_use is ignored, because the ID instruction is wrong-path.
//   else load_use -> PC_Stall=1, IF_ID_Stall=1, ID_EX_Bubble=1 for exactly one cycle.
//    Back-to-back detection cannot recur, because the bubble clears ID_EX_MemRead.
//   else all outputs 0.
//  State MEM_WAIT:
//   dmem_ready=1 -> all outputs 0 this cycle (the access completes); next state RUN; wait_cnt<=0.
//   else wait_cnt==MEM_TIMEOUT-1 -> mem_timeout<=1; outputs 0 this cycle; next state RUN.
//    The access is abandoned and software handles the error.
//   else full freeze as on entry; wait_cnt<=wait_cnt+1.
//   branch_taken and load_use are ignored in MEM_WAIT. Both stay visible after unfreeze because ID/EX is held.
//  Counters: stall_cnt increments on each cycle with PC_Stall=1; flush_cnt increments on each cycle with IF_ID_Flush=1.
//   Both hold at 2^CNT_W-1.
//  Reset asserted mid-MEM_WAIT returns to RUN the next edge; no pending freeze survives.
//  x0 is never a hazard source (Rd==0 excluded).
// STRUCTURE
//  Shared package pipe_ctrl_pkg: state encoding localparams ST_RUN=1'b0 and ST_MEM_WAIT=1'b1; REG_ZERO=5'd0.
//  Single sub-module sat_counter #(W) (enable, saturating) instantiated twice for stall_cnt and flush_cnt.
//  FSM and hazard logic stay in this module.
// TESTING
//  1 lw x5 in EX, add x6,x5,x1 in ID -> one cycle with PC_Stall=1, IF_ID_Stall=1, ID_EX_Bubble=1; stall_cnt 0->1.
//  2 ID_EX_Rd=0, ID_EX_MemRead=1, IF_ID_Rs1=0 -> no stall; all outputs 0.
//  3 branch_taken=1 together with a load_use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Stall=0; flush_cnt=1, stall_cnt=0.
//  4 EX_MEM_MemRead=1, dmem_ready low for 3 cycles then high:
//    Pipe_Freeze=1 for 3 cycles, 0 on the ready cycle; state returns to RUN; stall_cnt=3.
//  5 MEM_TIMEOUT=4, dmem_ready held 0 -> freeze for cycles 1-3;
//    cycle 4 drops the freeze and sets mem_timeout=1, which stays 1 until rst.
//  6 rst pulsed during MEM_WAIT -> next cycle all outputs 0, counters 0, state RUN;
//    CNT_W=2 with 5 stalls -> stall_cnt holds at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and register constants.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic             ID_EX_MemRead;
    logic [REG_W-1:0] ID_EX_Rd;
    logic [REG_W-1:0] IF_ID_Rs1;
    logic [REG_W-1:0] IF_ID_Rs2;
    logic             branch_taken;
    logic             EX_MEM_MemRead;
    logic             EX_MEM_MemWrite;
    logic             dmem_ready;

    logic             PC_Stall;
    logic             IF_ID_Stall;
    logic             IF_ID_Flush;
    logic             Control_Sig_Stall;
    logic             ID_EX_Bubble;
    logic             Pipe_Freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2, branch_taken,
               EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
        input  PC_Stall, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Bubble,
               Pipe_Freeze, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2, branch_taken,
               EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
        output PC_Stall, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Bubble,
               Pipe_Freeze, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Enabled up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze generation for a 5-stage pipeline: load-use, branch redirect and
// a watchdog-guarded wait-state FSM for slow data memory, plus event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              timeout_set;
    logic              timeout_q;
    logic              mem_busy, load_use;
    logic              pc_stall, ifid_stall, ifid_flush, ctl_stall, bubble, freeze;

    assign mem_busy = (bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite) & ~bus.dmem_ready;
    assign load_use = bus.ID_EX_MemRead & (bus.ID_EX_Rd != REG_ZERO) &
                      ((bus.ID_EX_Rd == bus.IF_ID_Rs1) | (bus.ID_EX_Rd == bus.IF_ID_Rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Priority freeze > flush > load-use; controls are forced low while in reset.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        ctl_stall   = 1'b0;
        bubble      = 1'b0;
        freeze      = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        ctl_stall  = 1'b1;
                        freeze     = 1'b1;
                        state_nxt  = ST_MEM_WAIT;
                        wait_nxt   = WAIT_W'(1);
                    end else if (bus.branch_taken) begin
                        ifid_flush = 1'b1;
                        bubble     = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        bubble     = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        state_nxt = ST_RUN;
                        wait_nxt  = '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abandon the access; software sees the sticky error.
                        timeout_set = 1'b1;
                        state_nxt   = ST_RUN;
                        wait_nxt    = '0;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        ctl_stall  = 1'b1;
                        freeze     = 1'b1;
                        wait_nxt   = wait_cnt + WAIT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.PC_Stall          = pc_stall;
    assign bus.IF_ID_Stall       = ifid_stall;
    assign bus.IF_ID_Flush       = ifid_flush;
    assign bus.Control_Sig_Stall = ctl_stall;
    assign bus.ID_EX_Bubble      = bubble;
    assign bus.Pipe_Freeze       = freeze;
    assign bus.mem_timeout       = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (pc_stall),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (ifid_flush),
        .cnt (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b uses MEM_TIMEOUT=4, CNT_W=2.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) a_if ();
    pipeline_hazard_ctrl_if #(.CNT_W(2))  b_if ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    // Control vector order: PC_Stall, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Bubble, Pipe_Freeze
    logic [5:0] a_ctl, b_ctl;
    assign a_ctl = {a_if.PC_Stall, a_if.IF_ID_Stall, a_if.IF_ID_Flush,
                    a_if.Control_Sig_Stall, a_if.ID_EX_Bubble, a_if.Pipe_Freeze};
    assign b_ctl = {b_if.PC_Stall, b_if.IF_ID_Stall, b_if.IF_ID_Flush,
                    b_if.Control_Sig_Stall, b_if.ID_EX_Bubble, b_if.Pipe_Freeze};

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LDUSE  = 6'b110010;
    localparam logic [5:0] C_FLUSH  = 6'b001010;
    localparam logic [5:0] C_FREEZE = 6'b110101;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1-2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.ID_EX_MemRead = 0; a_if.ID_EX_Rd = 0; a_if.IF_ID_Rs1 = 0; a_if.IF_ID_Rs2 = 0;
        a_if.branch_taken = 0; a_if.EX_MEM_MemRead = 0; a_if.EX_MEM_MemWrite = 0; a_if.dmem_ready = 0;
    endtask

    task automatic idle_b();
        b_if.ID_EX_MemRead = 0; b_if.ID_EX_Rd = 0; b_if.IF_ID_Rs1 = 0; b_if.IF_ID_Rs2 = 0;
        b_if.branch_taken = 0; b_if.EX_MEM_MemRead = 0; b_if.EX_MEM_MemWrite = 0; b_if.dmem_ready = 0;
    endtask

    initial begin
        idle_a();
        idle_b();
        rst_a = 1'b1;
        rst_b = 1'b1;
        // Hazard inputs present during reset must not produce controls.
        a_if.EX_MEM_MemRead = 1;
        #1;
        check("rst_ctl_a", 32'(a_ctl), 32'(C_NONE));
        tick();
        tick();
        check("rst_stall_cnt", a_if.stall_cnt, 0);
        check("rst_flush_cnt", a_if.flush_cnt, 0);
        check("rst_timeout", 32'(a_if.mem_timeout), 0);
        idle_a();
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("idle_ctl", 32'(a_ctl), 32'(C_NONE));

        // lw x5 in EX, add x6,x5,x1 in ID: one-cycle load-use stall
        tick();
        a_if.ID_EX_MemRead = 1; a_if.ID_EX_Rd = 5; a_if.IF_ID_Rs1 = 5; a_if.IF_ID_Rs2 = 1;
        #1;
        check("lduse_rs1_ctl", 32'(a_ctl), 32'(C_LDUSE));
        tick();
        idle_a();
        #1;
        check("lduse_cnt", a_if.stall_cnt, 1);
        check("lduse_after_ctl", 32'(a_ctl), 32'(C_NONE));

        // rs2 match also stalls
        a_if.ID_EX_MemRead = 1; a_if.ID_EX_Rd = 7; a_if.IF_ID_Rs1 = 3; a_if.IF_ID_Rs2 = 7;
        #1;
        check("lduse_rs2_ctl", 32'(a_ctl), 32'(C_LDUSE));
        tick();
        check("lduse_rs2_cnt", a_if.stall_cnt, 2);

        // Not a load: same register match is no hazard
        a_if.ID_EX_MemRead = 0;
        #1;
        check("noload_ctl", 32'(a_ctl), 32'(C_NONE));

        // x0 destination never stalls
        a_if.ID_EX_MemRead = 1; a_if.ID_EX_Rd = 0; a_if.IF_ID_Rs1 = 0; a_if.IF_ID_Rs2 = 0;
        #1;
        check("x0_ctl", 32'(a_ctl), 32'(C_NONE));
        tick();
        check("x0_cnt", a_if.stall_cnt, 2);

        // Branch together with load-use: flush wins, no PC stall
        a_if.ID_EX_MemRead = 1; a_if.ID_EX_Rd = 9; a_if.IF_ID_Rs1 = 9; a_if.branch_taken = 1;
        #1;
        check("branch_ctl", 32'(a_ctl), 32'(C_FLUSH));
        tick();
        idle_a();
        check("branch_flush_cnt", a_if.flush_cnt, 1);
        check("branch_stall_cnt", a_if.stall_cnt, 2);

        // Store with memory ready: no freeze
        a_if.EX_MEM_MemWrite = 1; a_if.dmem_ready = 1;
        #1;
        check("store_ready_ctl", 32'(a_ctl), 32'(C_NONE));
        tick();

        // Load with memory late for 3 cycles; branch/load-use ignored while waiting
        idle_a();
        a_if.EX_MEM_MemRead = 1;
        #1;
        check("wait1_ctl", 32'(a_ctl), 32'(C_FREEZE));
        tick();
        a_if.branch_taken = 1;
        #1;
        check("wait2_ctl", 32'(a_ctl), 32'(C_FREEZE));
        tick();
        a_if.branch_taken = 0;
        a_if.ID_EX_MemRead = 1; a_if.ID_EX_Rd = 4; a_if.IF_ID_Rs2 = 4;
        #1;
        check("wait3_ctl", 32'(a_ctl), 32'(C_FREEZE));
        tick();
        a_if.dmem_ready = 1;
        #1;
        check("ready_ctl", 32'(a_ctl), 32'(C_NONE));
        tick();
        idle_a();
        check("wait_stall_cnt", a_if.stall_cnt, 5);
        check("wait_flush_cnt", a_if.flush_cnt, 1);
        check("wait_no_timeout", 32'(a_if.mem_timeout), 0);
        // Back in RUN: a branch is honoured again
        a_if.branch_taken = 1;
        #1;
        check("run_again_ctl", 32'(a_ctl), 32'(C_FLUSH));
        tick();
        idle_a();
        check("run_again_flush_cnt", a_if.flush_cnt, 2);

        // dut_b: watchdog with MEM_TIMEOUT=4
        b_if.EX_MEM_MemWrite = 1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("to_freeze%0d", i), 32'(b_ctl), 32'(C_FREEZE));
            tick();
        end
        check("to_not_yet", 32'(b_if.mem_timeout), 0);
        #1;
        check("to_cycle4_ctl", 32'(b_ctl), 32'(C_NONE));
        tick();
        idle_b();
        check("to_flag", 32'(b_if.mem_timeout), 1);
        check("to_stall_cnt", b_if.stall_cnt, 3);
        tick();
        tick();
        check("to_sticky", 32'(b_if.mem_timeout), 1);

        // Two more stalls: 2-bit counter holds at 3
        b_if.ID_EX_MemRead = 1; b_if.ID_EX_Rd = 2; b_if.IF_ID_Rs1 = 2;
        #1;
        check("sat_ctl", 32'(b_ctl), 32'(C_LDUSE));
        tick();
        tick();
        idle_b();
        check("sat_cnt", b_if.stall_cnt, 3);

        // Reset during MEM_WAIT
        b_if.EX_MEM_MemRead = 1;
        tick();
        #1;
        check("pre_rst_ctl", 32'(b_ctl), 32'(C_FREEZE));
        rst_b = 1'b1;
        #1;
        check("in_rst_ctl", 32'(b_ctl), 32'(C_NONE));
        tick();
        rst_b = 1'b0;
        idle_b();
        #1;
        check("post_rst_ctl", 32'(b_ctl), 32'(C_NONE));
        check("post_rst_stall_cnt", b_if.stall_cnt, 0);
        check("post_rst_flush_cnt", b_if.flush_cnt, 0);
        check("post_rst_timeout", 32'(b_if.mem_timeout), 0);
        b_if.branch_taken = 1;
        #1;
        check("post_rst_run", 32'(b_ctl), 32'(C_FLUSH));
        tick();
        idle_b();
        check("post_rst_flush1", b_if.flush_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
